cpu_mem_unit: RTL and testbench

Program/data memory stage that sits directly on the CPU bus: decodes `adr_bus`, `rd_mem` and `wr_mem`, drives the CPU's `d_in` byte, and accepts the CPU's `d_out` byte on writes. It also owns a byte-stream loader that fills memory from address 0 before the CPU runs. The block replaces direct testbench driving of `d_in`. It contains a 64 x 8 register array, a clear sequencer, and a CLEAR/LOAD/RUN state machine.

---
 rtl/cpu_mem_unit.sv | 103 ++++++++++
 tb/tb_cpu_mem_unit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_unit.sv
// CPU-bus memory stage with power-up clear sequencer and byte-stream loader; reads are 1-cycle registered.
// The loader is never stalled inside LOAD, and the CPU bus has no wait states.
module cpu_mem_unit #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] adr_bus,
  input  logic              rd_mem,
  input  logic              wr_mem,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_done,
  output logic              ld_ready,
  output logic              ld_wrap,
  output logic              running,
  output logic              bus_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] ld_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_rd;
  logic              cpu_wr;
  logic              cpu_conflict;

  assign cpu_rd       = (state == ST_RUN) && rd_mem && !wr_mem;
  assign cpu_wr       = (state == ST_RUN) && wr_mem && !rd_mem;
  assign cpu_conflict = (state == ST_RUN) && wr_mem && rd_mem;

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    unique case (state)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr;
        if (clr_ptr == LAST_ADDR) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        mem_we    = ld_valid;
        mem_waddr = ld_ptr;
        mem_wdata = ld_data;
        if (ld_done) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        mem_we    = cpu_wr;
        mem_waddr = adr_bus;
        mem_wdata = cpu_wdata;
      end
      default: state_nxt = ST_CLEAR;
    endcase
    // Reset restarts the sequencer but must leave the array contents alone.
    if (!reset) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_CLEAR;
      clr_ptr   <= '0;
      ld_ptr    <= '0;
      cpu_rdata <= '0;
      ld_wrap   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) clr_ptr <= clr_ptr + 1'b1;
      if (state == ST_LOAD && ld_valid) begin
        ld_ptr <= ld_ptr + 1'b1;
        if (ld_ptr == LAST_ADDR) ld_wrap <= 1'b1;
      end
      if (cpu_rd)       cpu_rdata <= mem[adr_bus];
      if (cpu_conflict) bus_err   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign ld_ready = (state == ST_LOAD);
  assign running  = (state == ST_RUN);

endmodule

// File: tb/tb_cpu_mem_unit.sv
// Directed bench for cpu_mem_unit: clear timing, loader, wrap, CPU access, conflict, reset mid-load.
module tb_cpu_mem_unit;

  logic       clk;
  logic       reset;
  logic [5:0] adr_bus;
  logic       rd_mem;
  logic       wr_mem;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_done;
  logic       ld_ready;
  logic       ld_wrap;
  logic       running;
  logic       bus_err;

  int vectors;
  int miscompares;

  cpu_mem_unit #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .adr_bus(adr_bus), .rd_mem(rd_mem), .wr_mem(wr_mem),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_done(ld_done), .ld_ready(ld_ready), .ld_wrap(ld_wrap), .running(running),
    .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Returns the number of edges after reset release until ld_ready is seen (999 on timeout).
  task automatic wait_ready(output int n);
    n = 999;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (ld_ready) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic load_byte(input logic [7:0] b);
    ld_valid = 1'b1;
    ld_data  = b;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic finish_load();
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
  endtask

  task automatic cpu_read(input logic [5:0] a, output logic [7:0] d);
    adr_bus = a;
    rd_mem  = 1'b1;
    tick();
    rd_mem  = 1'b0;
    d = cpu_rdata;
  endtask

  task automatic cpu_write(input logic [5:0] a, input logic [7:0] d);
    adr_bus   = a;
    cpu_wdata = d;
    wr_mem    = 1'b1;
    tick();
    wr_mem    = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    logic [7:0] d;
    wait_ready(n);
    vectors++;
    if (n !== 64) begin
      miscompares++;
      $display("FAIL reset_powerup_ready: edges=%0d required=64", n);
    end
    for (int i = 0; i < 64; i++) load_byte(8'hFF);
    finish_load();
    cpu_read(6'd0, d);
    vectors++;
    if (d !== 8'hFF) begin
      miscompares++;
      $display("FAIL prefill_read: got=%h required=ff", d);
    end
    do_reset();
    vectors++;
    if ({cpu_rdata, ld_ready, ld_wrap, running, bus_err} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_outputs: rdata=%h rdy=%b wrap=%b run=%b err=%b required all 0",
               cpu_rdata, ld_ready, ld_wrap, running, bus_err);
    end
    wait_ready(n);
    vectors++;
    if (n !== 64) begin
      miscompares++;
      $display("FAIL clear_ready_latency: edges=%0d required=64", n);
    end
    finish_load();
    begin
      logic [5:0] addrs [3];
      addrs[0] = 6'd0; addrs[1] = 6'd31; addrs[2] = 6'd63;
      for (int i = 0; i < 3; i++) begin
        cpu_read(addrs[i], d);
        vectors++;
        if (d !== 8'h00) begin
          miscompares++;
          $display("FAIL clear_read a=%0d: got=%h required=00", addrs[i], d);
        end
      end
    end
  endtask

  task automatic test_load_read();
    int n;
    logic [7:0] d;
    do_reset();
    wait_ready(n);
    load_byte(8'h11);
    load_byte(8'h22);
    load_byte(8'h33);
    // CPU strobes during LOAD must be ignored
    cpu_read(6'd0, d);
    vectors++;
    if (d !== 8'h00) begin
      miscompares++;
      $display("FAIL load_ignores_rd: rdata=%h required=00", d);
    end
    cpu_write(6'd10, 8'h5A);
    finish_load();
    vectors++;
    if (running !== 1'b1 || ld_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL run_state: running=%b ld_ready=%b required 1/0", running, ld_ready);
    end
    cpu_read(6'd1, d);
    vectors++;
    if (d !== 8'h22) begin
      miscompares++;
      $display("FAIL load_read a=1: got=%h required=22", d);
    end
    cpu_read(6'd10, d);
    vectors++;
    if (d !== 8'h00) begin
      miscompares++;
      $display("FAIL load_ignores_wr: got=%h required=00", d);
    end
    // Loader inputs in RUN must be ignored
    load_byte(8'h77);
    finish_load();
    cpu_read(6'd3, d);
    vectors++;
    if (d !== 8'h00 || running !== 1'b1) begin
      miscompares++;
      $display("FAIL run_ignores_loader: got=%h running=%b required 00/1", d, running);
    end
  endtask

  task automatic test_wrap();
    int n;
    logic [7:0] d;
    do_reset();
    wait_ready(n);
    for (int i = 0; i < 63; i++) load_byte(8'(i));
    vectors++;
    if (ld_wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_early: ld_wrap=%b required=0", ld_wrap);
    end
    load_byte(8'h3F);
    vectors++;
    if (ld_wrap !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_set: ld_wrap=%b required=1", ld_wrap);
    end
    // 65th byte together with ld_done: byte lands first, then RUN
    ld_valid = 1'b1;
    ld_data  = 8'h40;
    ld_done  = 1'b1;
    tick();
    ld_valid = 1'b0;
    ld_done  = 1'b0;
    vectors++;
    if (running !== 1'b1 || ld_wrap !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_done: running=%b ld_wrap=%b required 1/1", running, ld_wrap);
    end
    cpu_read(6'd0, d);
    vectors++;
    if (d !== 8'h40) begin
      miscompares++;
      $display("FAIL wrap_read a=0: got=%h required=40", d);
    end
    cpu_read(6'd63, d);
    vectors++;
    if (d !== 8'h3F) begin
      miscompares++;
      $display("FAIL wrap_read a=63: got=%h required=3f", d);
    end
  endtask

  task automatic test_write_readback();
    logic [7:0] d;
    cpu_read(6'd5, d);
    vectors++;
    if (d !== 8'h05) begin
      miscompares++;
      $display("FAIL pre_write_read a=5: got=%h required=05", d);
    end
    cpu_write(6'd5, 8'hA5);
    vectors++;
    if (cpu_rdata !== 8'h05) begin
      miscompares++;
      $display("FAIL write_keeps_rdata: got=%h required=05", cpu_rdata);
    end
    cpu_read(6'd5, d);
    vectors++;
    if (d !== 8'hA5) begin
      miscompares++;
      $display("FAIL write_readback a=5: got=%h required=a5", d);
    end
  endtask

  task automatic test_bus_conflict();
    logic [7:0] d;
    cpu_read(6'd7, d);
    vectors++;
    if (bus_err !== 1'b0) begin
      miscompares++;
      $display("FAIL bus_err_idle: got=%b required=0", bus_err);
    end
    adr_bus   = 6'd2;
    cpu_wdata = 8'h99;
    rd_mem    = 1'b1;
    wr_mem    = 1'b1;
    tick();
    rd_mem = 1'b0;
    wr_mem = 1'b0;
    vectors++;
    if (bus_err !== 1'b1 || cpu_rdata !== 8'h07) begin
      miscompares++;
      $display("FAIL conflict: bus_err=%b rdata=%h required 1/07", bus_err, cpu_rdata);
    end
    tick();
    tick();
    cpu_read(6'd2, d);
    vectors++;
    if (d !== 8'h02 || bus_err !== 1'b1) begin
      miscompares++;
      $display("FAIL conflict_after: mem2=%h bus_err=%b required 02/1", d, bus_err);
    end
  endtask

  task automatic test_reset_mid_load();
    int n;
    logic [7:0] d;
    do_reset();
    wait_ready(n);
    for (int i = 0; i < 10; i++) load_byte(8'hC0 + 8'(i));
    do_reset();
    vectors++;
    if (ld_ready !== 1'b0 || ld_wrap !== 1'b0 || bus_err !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_load_reset: rdy=%b wrap=%b err=%b required 0/0/0", ld_ready, ld_wrap, bus_err);
    end
    wait_ready(n);
    vectors++;
    if (n !== 64) begin
      miscompares++;
      $display("FAIL mid_load_ready_latency: edges=%0d required=64", n);
    end
    load_byte(8'h7E);
    finish_load();
    cpu_read(6'd0, d);
    vectors++;
    if (d !== 8'h7E) begin
      miscompares++;
      $display("FAIL mid_load_read a=0: got=%h required=7e", d);
    end
    cpu_read(6'd1, d);
    vectors++;
    if (d !== 8'h00 || ld_wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_load_read a=1: got=%h wrap=%b required 00/0", d, ld_wrap);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset     = 1'b0;
    adr_bus   = '0;
    rd_mem    = 1'b0;
    wr_mem    = 1'b0;
    cpu_wdata = '0;
    ld_valid  = 1'b0;
    ld_data   = '0;
    ld_done   = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    test_reset();
    test_load_read();
    test_wrap();
    test_write_readback();
    test_bus_conflict();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
